npc_predictor: RTL and testbench
================================

NPC_PREDICTOR -- requirements
Module: npc_predictor

Interface
REQ-001 Parameter ENTRIES, default 16: BTB depth; power of two, 4..256; IDX = log2(ENTRIES).
REQ-002 Parameter RESET_PC, default 32'h0000_3000: PC value after reset.
REQ-003 Parameter CTR_INIT, default 2'b01: reset value of every 2-bit direction counter.
REQ-004 Parameter DELAY_SLOT, default 0: 1 = MIPS delay-slot mode, 0 = no delay slot with prediction.
REQ-005 One clock; reset is synchronous and active-low. Ports, in order:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low
stall  in  1  freeze F and D; hold all state
d_valid  in  1  D-stage instruction valid
d_op  in  6  D opcode
d_funct  in  6  D funct
d_pc  in  32  D instruction address
d_offset  in  16  branch immediate
d_dst  in  26  jump index
d_regdst  in  32  forwarded rs value
d_equal  in  1  rs==rt
d_nequal  in  1  rs!=rt
pc_f  out  32  current fetch PC
link  out  32  link address for JAL/JALR
flush_d  out  1  discard instruction now in F (do not latch into D)
redirect  out  1  D-resolved next PC overrides prediction this cycle
n_branch  out  32  resolved control-transfer count
n_mispred  out  32  misprediction count

Function
REQ-006 Decoded ops: BEQ 000100, BNE 000101, J 000010, JAL 000011, R 000000 with funct JR 001000 or JALR 001001; other ops are not control transfers.
REQ-007 Targets: branch = d_pc+4+sext(d_offset)<<2; J/JAL = {d_pc[31:28], d_dst, 2'b00}; JR/JALR = d_regdst; 32-bit, wrap modulo 2^32.
REQ-008 Actual next (actual_np): BEQ taken iff d_equal, BNE taken iff d_nequal, jumps always taken; taken -> target, else d_pc+4 (DELAY_SLOT=0) or d_pc+8 (DELAY_SLOT=1).
REQ-009 link = d_pc+4 when DELAY_SLOT=0, d_pc+8 when 1.
REQ-010 BTB entry: valid, tag = pc[31:IDX+2], 32-bit target, 2-bit counter; index = pc[IDX+1:2].
REQ-011 F prediction (DELAY_SLOT=0): hit on pc_f and counter[1]=1, or hit on a jump entry -> pred_np = target; else pred_np = pc_f+4.
REQ-012 pred_np and the predicted-taken bit move into an internal F->D register on every non-stalled edge; cleared when flush_d is sampled.
REQ-013 Mispredict: d_valid, control transfer, !stall, actual_np != registered pred_np; then redirect=1, flush_d=1, pc_f <= actual_np next edge.
REQ-014 Otherwise, when !stall, pc_f <= pred_np; when stall, pc_f, F->D register, BTB and statistics hold; redirect=flush_d=0.
REQ-015 BTB update on a resolved control transfer, !stall: taken -> write tag and target, set valid, counter +1 saturating at 3 (new allocation: counter = 2'b10); not taken on hit -> counter -1 saturating at 0; not taken on miss -> no write.
REQ-016 Jump entries (J/JAL/JR/JALR) carry a jump flag; prediction ignores the counter for them.
REQ-017 Same-index F read and D write in one cycle: read returns old contents (write takes effect next cycle).
REQ-018 DELAY_SLOT=1: BTB lookup disabled, pred_np = pc_f+4, flush_d always 0; a control transfer in D drives pc_f <= actual_np, with redirect=1 when taken.
REQ-019 n_branch +1 per resolved control transfer; n_mispred +1 per REQ-013 event; both saturate at 32'hFFFF_FFFF.

Reset
REQ-020 reset=0 at an edge: pc_f=RESET_PC, all valid=0, counters=CTR_INIT, F->D register cleared, n_branch=n_mispred=0; redirect=flush_d=0 while reset is low.
REQ-021 Reset overrides stall and an in-progress mispredict; no BTB write occurs in the reset cycle.

Structure
REQ-022 Opcode/funct constants, RESET_PC default and counter encodings live in the shared defines package.
REQ-023 One sub-module, npc_btb: ENTRIES-deep table, one async read port, one sync write port.

Verification
REQ-024 Reset release with no branches -> pc_f 0x3000, 0x3004, 0x3008; counters 0.
REQ-025 BEQ at 0x3010, offset 4, d_equal=1, cold BTB -> flush_d=1, pc_f=0x3024, n_mispred=1; same BEQ again -> no flush, pc_f follows 0x3024.
REQ-026 JR at 0x3040, regdst 0x3100, twice -> first mispredict, second predicted; n_branch=2, n_mispred=1.
REQ-027 BNE, d_nequal=1 four times then 0 -> counter 2,3,3,3 then 2; still predicted taken; last is a mispredict.
REQ-028 stall=1 for 3 cycles during mispredict -> pc_f held, no BTB write, single n_mispred increment after release.
REQ-029 DELAY_SLOT=1, JAL at 0x3000 -> link=0x3008, flush_d=0, pc_f: 0x3004 then target.

Source files
------------

// File: rtl/npc_predictor_pkg.sv
// -----------------------------------------------------------------------------
// npc_predictor_pkg
// Shared definitions for the next-PC predictor slice:
//   - MIPS opcode / funct encodings of the control-transfer instructions
//   - default reset PC
//   - 2-bit direction counter encodings and saturating helpers
//   - control-transfer kind decoded from opcode/funct
// -----------------------------------------------------------------------------
package npc_predictor_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    // Opcodes
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    // R-type funct codes
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;

    // Direction counter encodings; bit 1 set means "predict taken"
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    // Control-transfer kind seen in D
    typedef enum logic [2:0] {
        CT_NONE = 3'd0,
        CT_BEQ  = 3'd1,
        CT_BNE  = 3'd2,
        CT_J    = 3'd3,   // J / JAL: pseudo-direct target
        CT_JR   = 3'd4    // JR / JALR: register target
    } ctl_kind_t;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_ST) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? c : c - 2'd1;
    endfunction

    function automatic ctl_kind_t decode_ctl(input logic [5:0] op, input logic [5:0] funct);
        ctl_kind_t k;
        k = CT_NONE;
        case (op)
            OP_BEQ:        k = CT_BEQ;
            OP_BNE:        k = CT_BNE;
            OP_J, OP_JAL:  k = CT_J;
            OP_R: begin
                if (funct == FN_JR || funct == FN_JALR) k = CT_JR;
            end
            default:       k = CT_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/npc_btb.sv
// -----------------------------------------------------------------------------
// npc_btb
// Direct-mapped branch target buffer, ENTRIES deep.
// Each entry: valid, tag, 32-bit target, jump flag, 2-bit direction counter.
//
// Ports:
//   clk, reset      clock, synchronous active-low reset (clears valid bits,
//                   loads every counter with CTR_INIT)
//   rd_idx          asynchronous read index (fetch PC)
//   rd_valid/tag/target/jump/ctr   entry contents at rd_idx
//   wr_en           resolve a control transfer into the table this edge
//   wr_idx, wr_tag  entry selected by the resolved instruction's PC
//   wr_target       resolved target
//   wr_jump         instruction is an unconditional jump
//   wr_taken        resolved direction
//
// The write port is read-modify-write on the counter: taken allocates or
// strengthens the entry, not-taken weakens it only when the tag matches.
// Reads see the contents before this edge's write.
// -----------------------------------------------------------------------------
module npc_btb
    import npc_predictor_pkg::*;
#(
    parameter int         ENTRIES  = 16,
    parameter int         IDX      = $clog2(ENTRIES),
    parameter int         TAGW     = 30 - IDX,
    parameter logic [1:0] CTR_INIT = CTR_WNT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IDX-1:0]  rd_idx,
    output logic            rd_valid,
    output logic [TAGW-1:0] rd_tag,
    output logic [31:0]     rd_target,
    output logic            rd_jump,
    output logic [1:0]      rd_ctr,
    input  logic            wr_en,
    input  logic [IDX-1:0]  wr_idx,
    input  logic [TAGW-1:0] wr_tag,
    input  logic [31:0]     wr_target,
    input  logic            wr_jump,
    input  logic            wr_taken
);

    logic            valid  [ENTRIES];
    logic [TAGW-1:0] tag    [ENTRIES];
    logic [31:0]     target [ENTRIES];
    logic            jump   [ENTRIES];
    logic [1:0]      ctr    [ENTRIES];

    logic wr_hit;

    assign rd_valid  = valid[rd_idx];
    assign rd_tag    = tag[rd_idx];
    assign rd_target = target[rd_idx];
    assign rd_jump   = jump[rd_idx];
    assign rd_ctr    = ctr[rd_idx];

    assign wr_hit = valid[wr_idx] && (tag[wr_idx] == wr_tag);

    // Valid bits and counters: reset, then RMW on resolved transfers
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= CTR_INIT;
            end
        end else if (wr_en) begin
            if (wr_taken) begin
                valid[wr_idx] <= 1'b1;
                // A fresh allocation starts weakly taken
                ctr[wr_idx]   <= wr_hit ? ctr_inc(ctr[wr_idx]) : CTR_WT;
            end else if (wr_hit) begin
                ctr[wr_idx]   <= ctr_dec(ctr[wr_idx]);
            end
        end
    end

    // Payload needs no reset: it is ignored while valid is low
    always_ff @(posedge clk) begin
        if (reset && wr_en && wr_taken) begin
            tag[wr_idx]    <= wr_tag;
            target[wr_idx] <= wr_target;
            jump[wr_idx]   <= wr_jump;
        end
    end

endmodule

// File: rtl/npc_predictor.sv
// -----------------------------------------------------------------------------
// npc_predictor
// Next-PC generation for a two-stage F/D front end with BTB prediction and
// D-stage resolution of BEQ/BNE/J/JAL/JR/JALR.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-low reset
//   stall        freeze F and D; all state holds
//   d_valid, d_op, d_funct, d_pc, d_offset, d_dst, d_regdst,
//   d_equal, d_nequal            D-stage instruction and operand compare
//   pc_f         current fetch PC
//   link         return address for JAL/JALR
//   flush_d      instruction in F must not be latched into D
//   redirect     D-resolved next PC overrides the prediction this cycle
//   n_branch     resolved control transfers (saturating)
//   n_mispred    mispredictions (saturating)
//
// Handshake: there is no valid/ready pair here. d_valid qualifies the D
// inputs in the same cycle; stall is a global hold that blocks every state
// update, so a transfer is resolved exactly once, on its first unstalled edge.
//
// DELAY_SLOT=0: F looks up the BTB; the prediction rides along in the F->D
// register and is compared with the resolved next PC in D.
// DELAY_SLOT=1: fetch is always sequential; a control transfer in D simply
// loads its resolved next PC (the delay slot is already in F).
// -----------------------------------------------------------------------------
module npc_predictor
    import npc_predictor_pkg::*;
#(
    parameter int          ENTRIES    = 16,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [1:0]  CTR_INIT   = CTR_WNT,
    parameter bit          DELAY_SLOT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        d_valid,
    input  logic [5:0]  d_op,
    input  logic [5:0]  d_funct,
    input  logic [31:0] d_pc,
    input  logic [15:0] d_offset,
    input  logic [25:0] d_dst,
    input  logic [31:0] d_regdst,
    input  logic        d_equal,
    input  logic        d_nequal,
    output logic [31:0] pc_f,
    output logic [31:0] link,
    output logic        flush_d,
    output logic        redirect,
    output logic [31:0] n_branch,
    output logic [31:0] n_mispred
);

    localparam int          IDX      = $clog2(ENTRIES);
    localparam int          TAGW     = 30 - IDX;
    localparam logic [31:0] SEQ_STEP = DELAY_SLOT ? 32'd8 : 32'd4;

    // ---------------- D-stage resolution ----------------
    ctl_kind_t   kind;
    logic        is_ctl;
    logic        is_jump;
    logic        taken;
    logic [31:0] target;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] actual_np;
    logic        resolved;

    assign kind      = decode_ctl(d_op, d_funct);
    assign is_ctl    = (kind != CT_NONE);
    assign is_jump   = (kind == CT_J) || (kind == CT_JR);
    assign br_target = d_pc + 32'd4 + {{14{d_offset[15]}}, d_offset, 2'b00};
    assign j_target  = {d_pc[31:28], d_dst, 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = br_target;
        case (kind)
            CT_BEQ:  taken = d_equal;
            CT_BNE:  taken = d_nequal;
            CT_J: begin
                taken  = 1'b1;
                target = j_target;
            end
            CT_JR: begin
                taken  = 1'b1;
                target = d_regdst;
            end
            default: taken = 1'b0;
        endcase
    end

    assign actual_np = taken ? target : d_pc + SEQ_STEP;
    assign link      = d_pc + SEQ_STEP;
    assign resolved  = reset && !stall && d_valid && is_ctl;

    // ---------------- F-stage prediction ----------------
    logic            rd_valid;
    logic [TAGW-1:0] rd_tag;
    logic [31:0]     rd_target;
    logic            rd_jump;
    logic [1:0]      rd_ctr;
    logic            f_hit;
    logic            f_taken;
    logic [31:0]     pred_np;

    assign f_hit   = rd_valid && (rd_tag == pc_f[31:IDX+2]);
    assign f_taken = !DELAY_SLOT && f_hit && (rd_jump || rd_ctr[1]);
    assign pred_np = f_taken ? rd_target : pc_f + 32'd4;

    // ---------------- F->D prediction register ----------------
    logic [31:0] fd_pred_np;
    logic        fd_pred_taken;
    logic        fd_taken_unused;

    // The direction bit travels with the instruction for D-side consumers;
    // the redirect decision itself only needs the predicted address.
    assign fd_taken_unused = fd_pred_taken;

    logic mispred;

    // In delay-slot mode sequential fetch is the implicit prediction, so only
    // a taken transfer departs from it.
    assign mispred  = resolved && (DELAY_SLOT ? taken : (actual_np != fd_pred_np));
    assign redirect = DELAY_SLOT ? (resolved && taken) : mispred;
    assign flush_d  = !DELAY_SLOT && mispred;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_f          <= RESET_PC;
            fd_pred_np    <= '0;
            fd_pred_taken <= 1'b0;
            n_branch      <= '0;
            n_mispred     <= '0;
        end else if (!stall) begin
            if (DELAY_SLOT ? resolved : mispred) pc_f <= actual_np;
            else                                 pc_f <= pred_np;

            if (flush_d) begin
                fd_pred_np    <= '0;
                fd_pred_taken <= 1'b0;
            end else begin
                fd_pred_np    <= pred_np;
                fd_pred_taken <= f_taken;
            end

            if (resolved && (n_branch != 32'hFFFF_FFFF))  n_branch  <= n_branch + 32'd1;
            if (mispred  && (n_mispred != 32'hFFFF_FFFF)) n_mispred <= n_mispred + 32'd1;
        end
    end

    // ---------------- BTB ----------------
    npc_btb #(
        .ENTRIES  (ENTRIES),
        .IDX      (IDX),
        .TAGW     (TAGW),
        .CTR_INIT (CTR_INIT)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (pc_f[IDX+1:2]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_target (rd_target),
        .rd_jump   (rd_jump),
        .rd_ctr    (rd_ctr),
        .wr_en     (resolved && !DELAY_SLOT),
        .wr_idx    (d_pc[IDX+1:2]),
        .wr_tag    (d_pc[31:IDX+2]),
        .wr_target (target),
        .wr_jump   (is_jump),
        .wr_taken  (taken)
    );

endmodule

// File: tb/tb_npc_predictor.sv
// -----------------------------------------------------------------------------
// tb_npc_predictor
// Directed bench for npc_predictor. Two instances share all inputs:
// dut (no delay slot, BTB prediction) and dut_ds (delay-slot mode).
// D-stage inputs are driven 1 time unit after the rising edge; combinational
// outputs are checked after a further unit, registered outputs after the next
// edge. Expected values are hand-computed for each step.
// -----------------------------------------------------------------------------
module tb_npc_predictor;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] FN_JR  = 6'b001000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        d_valid;
    logic [5:0]  d_op;
    logic [5:0]  d_funct;
    logic [31:0] d_pc;
    logic [15:0] d_offset;
    logic [25:0] d_dst;
    logic [31:0] d_regdst;
    logic        d_equal;
    logic        d_nequal;

    logic [31:0] pc_f, link, n_branch, n_mispred;
    logic        flush_d, redirect;
    logic [31:0] ds_pc_f, ds_link, ds_n_branch, ds_n_mispred;
    logic        ds_flush_d, ds_redirect;

    int n_cmp = 0;
    int n_err = 0;

    npc_predictor dut (
        .clk(clk), .reset(reset), .stall(stall), .d_valid(d_valid),
        .d_op(d_op), .d_funct(d_funct), .d_pc(d_pc), .d_offset(d_offset),
        .d_dst(d_dst), .d_regdst(d_regdst), .d_equal(d_equal), .d_nequal(d_nequal),
        .pc_f(pc_f), .link(link), .flush_d(flush_d), .redirect(redirect),
        .n_branch(n_branch), .n_mispred(n_mispred)
    );

    npc_predictor #(.DELAY_SLOT(1'b1)) dut_ds (
        .clk(clk), .reset(reset), .stall(stall), .d_valid(d_valid),
        .d_op(d_op), .d_funct(d_funct), .d_pc(d_pc), .d_offset(d_offset),
        .d_dst(d_dst), .d_regdst(d_regdst), .d_equal(d_equal), .d_nequal(d_nequal),
        .pc_f(ds_pc_f), .link(ds_link), .flush_d(ds_flush_d), .redirect(ds_redirect),
        .n_branch(ds_n_branch), .n_mispred(ds_n_mispred)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic d_idle();
        d_valid  = 1'b0;
        d_op     = 6'b100011;   // LW: not a control transfer
        d_funct  = 6'd0;
        d_pc     = 32'd0;
        d_offset = 16'd0;
        d_dst    = 26'd0;
        d_regdst = 32'd0;
        d_equal  = 1'b0;
        d_nequal = 1'b0;
    endtask

    task automatic d_set(input logic [5:0] op, input logic [5:0] funct,
                         input logic [31:0] pc, input logic [15:0] off,
                         input logic [25:0] dst, input logic [31:0] regdst,
                         input logic eq);
        d_valid  = 1'b1;
        d_op     = op;
        d_funct  = funct;
        d_pc     = pc;
        d_offset = off;
        d_dst    = dst;
        d_regdst = regdst;
        d_equal  = eq;
        d_nequal = !eq;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        stall = 1'b0;
        d_idle();
        tick();
        tick();
        reset = 1'b1;
    endtask

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b0;
        stall = 1'b1;
        d_idle();

        // Reset wins over stall and over a would-be mispredict in D
        tick();
        d_set(OP_J, 6'd0, 32'h0000_3000, 16'd0, 26'h0000C80, 32'd0, 1'b0);
        tick();
        settle();
        chk("rst_pc", pc_f, 32'h0000_3000);
        chk("rst_nb", n_branch, 32'd0);
        chk("rst_nm", n_mispred, 32'd0);
        chk("rst_flush", {31'd0, flush_d}, 32'd0);
        chk("rst_redir", {31'd0, redirect}, 32'd0);

        // Sequential fetch after release
        d_idle();
        stall = 1'b0;
        reset = 1'b1;
        tick(); chk("seq_3004", pc_f, 32'h0000_3004);
        tick(); chk("seq_3008", pc_f, 32'h0000_3008);
        chk("seq_nb", n_branch, 32'd0);
        tick(); tick(); chk("seq_3010", pc_f, 32'h0000_3010);
        tick(); chk("seq_3014", pc_f, 32'h0000_3014);

        // BEQ at 0x3010, offset 4, taken, cold BTB
        d_set(OP_BEQ, 6'd0, 32'h0000_3010, 16'd4, 26'd0, 32'd0, 1'b1);
        settle();
        chk("beq1_flush", {31'd0, flush_d}, 32'd1);
        chk("beq1_redir", {31'd0, redirect}, 32'd1);
        tick();
        chk("beq1_pc", pc_f, 32'h0000_3024);
        chk("beq1_nm", n_mispred, 32'd1);
        chk("beq1_nb", n_branch, 32'd1);
        d_idle();
        settle();
        chk("beq1_noflush", {31'd0, flush_d}, 32'd0);
        tick(); chk("beq1_fall", pc_f, 32'h0000_3028);

        // J at 0x3024 back to 0x3010 (cold -> mispredict)
        d_set(OP_J, 6'd0, 32'h0000_3024, 16'd0, 26'h0000C04, 32'd0, 1'b0);
        settle();
        chk("jback_flush", {31'd0, flush_d}, 32'd1);
        tick();
        chk("jback_pc", pc_f, 32'h0000_3010);
        d_idle();
        tick(); chk("beq2_pred", pc_f, 32'h0000_3024);

        // Same BEQ again: predicted, no flush
        d_set(OP_BEQ, 6'd0, 32'h0000_3010, 16'd4, 26'd0, 32'd0, 1'b1);
        settle();
        chk("beq2_flush", {31'd0, flush_d}, 32'd0);
        chk("beq2_redir", {31'd0, redirect}, 32'd0);
        tick();
        chk("jpred_pc", pc_f, 32'h0000_3010);
        d_set(OP_J, 6'd0, 32'h0000_3024, 16'd0, 26'h0000C04, 32'd0, 1'b0);
        settle();
        chk("j2_flush", {31'd0, flush_d}, 32'd0);
        tick();
        chk("j2_pc", pc_f, 32'h0000_3024);
        chk("a_nb", n_branch, 32'd4);
        chk("a_nm", n_mispred, 32'd2);

        // JR at 0x3040 -> 0x3100, twice
        do_reset();
        d_idle();
        for (int i = 0; i < 16; i++) tick();
        chk("jr_reach", pc_f, 32'h0000_3040);
        tick();
        d_set(OP_R, FN_JR, 32'h0000_3040, 16'd0, 26'd0, 32'h0000_3100, 1'b0);
        settle();
        chk("jr1_flush", {31'd0, flush_d}, 32'd1);
        tick();
        chk("jr1_pc", pc_f, 32'h0000_3100);
        d_idle();
        tick(); tick();
        chk("jr_seq", pc_f, 32'h0000_3108);
        d_set(OP_J, 6'd0, 32'h0000_3104, 16'd0, 26'h0000C10, 32'd0, 1'b0);
        tick();
        chk("jr_back", pc_f, 32'h0000_3040);
        d_idle();
        tick();
        chk("jr2_pred", pc_f, 32'h0000_3100);
        d_set(OP_R, FN_JR, 32'h0000_3040, 16'd0, 26'd0, 32'h0000_3100, 1'b0);
        settle();
        chk("jr2_flush", {31'd0, flush_d}, 32'd0);
        tick();
        chk("jr2_pc", pc_f, 32'h0000_3104);
        chk("jr_nb", n_branch, 32'd3);
        chk("jr_nm", n_mispred, 32'd2);

        // BNE self-loop at 0x3060: counter 2,3,3,3 then down
        do_reset();
        d_idle();
        tick();
        d_set(OP_J, 6'd0, 32'h0000_3000, 16'd0, 26'h0000C18, 32'd0, 1'b0);
        tick();
        chk("bne_enter", pc_f, 32'h0000_3060);
        d_idle();
        tick();
        chk("bne_cold", pc_f, 32'h0000_3064);
        d_set(OP_BNE, 6'd0, 32'h0000_3060, 16'hFFFF, 26'd0, 32'd0, 1'b0);
        settle();
        chk("bne1_flush", {31'd0, flush_d}, 32'd1);
        tick();
        chk("bne1_pc", pc_f, 32'h0000_3060);
        d_idle();
        tick();
        chk("bne_ctr2_pred", pc_f, 32'h0000_3060);
        for (int i = 0; i < 3; i++) begin
            d_set(OP_BNE, 6'd0, 32'h0000_3060, 16'hFFFF, 26'd0, 32'd0, 1'b0);
            settle();
            chk("bne_loop_flush", {31'd0, flush_d}, 32'd0);
            tick();
            chk("bne_loop_pc", pc_f, 32'h0000_3060);
        end
        chk("bne_loop_nb", n_branch, 32'd5);
        chk("bne_loop_nm", n_mispred, 32'd2);
        d_set(OP_BNE, 6'd0, 32'h0000_3060, 16'hFFFF, 26'd0, 32'd0, 1'b1);
        settle();
        chk("bne_nt1_flush", {31'd0, flush_d}, 32'd1);
        tick();
        chk("bne_nt1_pc", pc_f, 32'h0000_3064);
        d_idle();
        tick();
        d_set(OP_J, 6'd0, 32'h0000_3064, 16'd0, 26'h0000C18, 32'd0, 1'b0);
        tick();
        chk("bne_reenter", pc_f, 32'h0000_3060);
        d_idle();
        tick();
        chk("bne_still_taken", pc_f, 32'h0000_3060);
        d_set(OP_BNE, 6'd0, 32'h0000_3060, 16'hFFFF, 26'd0, 32'd0, 1'b1);
        settle();
        chk("bne_nt2_flush", {31'd0, flush_d}, 32'd1);
        tick();
        chk("bne_nt2_nm", n_mispred, 32'd5);
        d_idle();
        tick();
        chk("bne_jpred", pc_f, 32'h0000_3060);
        d_set(OP_J, 6'd0, 32'h0000_3064, 16'd0, 26'h0000C18, 32'd0, 1'b0);
        tick();
        chk("bne_ctr1_nt", pc_f, 32'h0000_3064);
        d_set(OP_BNE, 6'd0, 32'h0000_3060, 16'hFFFF, 26'd0, 32'd0, 1'b1);
        settle();
        chk("bne_nt3_flush", {31'd0, flush_d}, 32'd0);
        tick();
        chk("bne_nb", n_branch, 32'd10);
        chk("bne_nm", n_mispred, 32'd5);

        // Stall across a pending mispredict
        do_reset();
        d_idle();
        tick();
        d_set(OP_J, 6'd0, 32'h0000_3000, 16'd0, 26'h0000C80, 32'd0, 1'b0);
        stall = 1'b1;
        settle();
        chk("stl_flush", {31'd0, flush_d}, 32'd0);
        chk("stl_redir", {31'd0, redirect}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_pc", pc_f, 32'h0000_3004);
            chk("stl_nm", n_mispred, 32'd0);
        end
        stall = 1'b0;
        settle();
        chk("stl_rel_flush", {31'd0, flush_d}, 32'd1);
        tick();
        chk("stl_rel_pc", pc_f, 32'h0000_3200);
        chk("stl_rel_nm", n_mispred, 32'd1);
        chk("stl_rel_nb", n_branch, 32'd1);

        // Delay-slot instance: JAL at 0x3000
        do_reset();
        d_idle();
        chk("ds_rst_pc", ds_pc_f, 32'h0000_3000);
        tick();
        chk("ds_slot_pc", ds_pc_f, 32'h0000_3004);
        d_set(OP_JAL, 6'd0, 32'h0000_3000, 16'd0, 26'h0000D00, 32'd0, 1'b0);
        settle();
        chk("ds_link", ds_link, 32'h0000_3008);
        chk("nods_link", link, 32'h0000_3004);
        chk("ds_flush", {31'd0, ds_flush_d}, 32'd0);
        chk("ds_redir", {31'd0, ds_redirect}, 32'd1);
        tick();
        chk("ds_target", ds_pc_f, 32'h0000_3400);
        d_set(OP_BEQ, 6'd0, 32'h0000_33FC, 16'd8, 26'd0, 32'd0, 1'b0);
        settle();
        chk("ds_nt_redir", {31'd0, ds_redirect}, 32'd0);
        tick();
        chk("ds_nt_pc", ds_pc_f, 32'h0000_3404);
        chk("ds_nb", ds_n_branch, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
